// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - operand/result bundle between a requester and the bit-serial adder
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, cout
    );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - one full-adder cell time-shared LSB-first across a WIDTH-bit word
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;

    logic             sum_bit;
    logic             carry;
    logic [WIDTH-1:0] r_shift;
    logic             accept;

    assign sum_bit = a_q[0] ^ b_q[0] ^ c_q;
    assign carry   = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        cout_d  = cout_q;
        accept  = 1'b0;

        // New sum bit enters at the MSB so the word is aligned after WIDTH shifts
        r_shift            = r_q >> 1;
        r_shift[WIDTH-1]   = sum_bit;

        case (state_q)
            IDLE: begin
                accept = bus.start;
            end
            ADD: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry;
                r_d   = r_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    s_d     = r_shift;
                    cout_d  = carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                accept = bus.start;
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            c_d     = bus.cin;
            cnt_d   = '0;
            state_d = ADD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == ADD);
    assign bus.done = (state_q == DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - table and scoreboard bench for WIDTH=8 and WIDTH=1 serial adders
module tb_serial_adder;
    logic clk;
    logic rst;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       cout;
    } vec_t;

    vec_t       tbl [7];
    logic [8:0] q8 [$];
    logic [1:0] q1 [$];
    int         n_vec = 0;
    int         n_mis = 0;
    logic [7:0] prev_s8 = 8'h00;
    logic       prev_c8 = 1'b0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (if8.busy && if8.done) chk("w8_busy_and_done", 1, 0);
            if (if1.busy && if1.done) chk("w1_busy_and_done", 1, 0);
            if (if8.done) begin
                if (q8.size() == 0) chk("w8_unexpected_done", 1, 0);
                else chk("w8_result", {if8.cout, if8.s}, q8.pop_front());
            end
            if (if1.done) begin
                if (q1.size() == 0) chk("w1_unexpected_done", 1, 0);
                else chk("w1_result", {if1.cout, if1.s}, q1.pop_front());
            end
        end
    end

    // Called just after the accepted start edge; returns in the cycle done is seen
    task automatic wait_done8(input int inject_at, output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (!if8.done && cyc < 40) begin
            if (if8.busy) bcnt++;
            if (cyc == 4) begin
                chk("hold_s", if8.s, prev_s8);
                chk("hold_cout", if8.cout, prev_c8);
            end
            if (cyc == inject_at) begin
                if8.start = 1'b1;
                if8.a     = 8'hAA;
                if8.b     = 8'hAA;
            end else begin
                if8.start = 1'b0;
            end
            step();
            cyc++;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic [7:0] es, input logic ec, input int inject_at, input string tag);
        int cyc;
        int bcnt;
        if8.a     = a;
        if8.b     = b;
        if8.cin   = cin;
        if8.start = 1'b1;
        q8.push_back({ec, es});
        step();
        wait_done8(inject_at, cyc, bcnt);
        chk({tag, "_latency"}, cyc, 9);
        chk({tag, "_busy_cycles"}, bcnt, 8);
        prev_s8 = es;
        prev_c8 = ec;
    endtask

    initial begin
        tbl[0] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, cout: 1'b1};
        tbl[1] = '{a: 8'h12, b: 8'h34, cin: 1'b1, s: 8'h47, cout: 1'b0};
        tbl[2] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, cout: 1'b1};
        tbl[3] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, cout: 1'b1};
        tbl[4] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, cout: 1'b0};
        tbl[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, s: 8'h00, cout: 1'b1};
        tbl[6] = '{a: 8'h3C, b: 8'h0F, cin: 1'b1, s: 8'h4C, cout: 1'b0};

        rst       = 1'b1;
        if8.start = 1'b1;
        if8.a     = 8'h55;
        if8.b     = 8'h55;
        if8.cin   = 1'b1;
        if1.start = 1'b1;
        if1.a     = 1'b1;
        if1.b     = 1'b1;
        if1.cin   = 1'b1;
        step();
        step();
        chk("rst_busy8", if8.busy, 0);
        chk("rst_done8", if8.done, 0);
        chk("rst_s8", if8.s, 0);
        chk("rst_cout8", if8.cout, 0);
        chk("rst_busy1", if1.busy, 0);
        chk("rst_done1", if1.done, 0);
        chk("rst_s1", if1.s, 0);
        chk("rst_cout1", if1.cout, 0);
        rst       = 1'b0;
        if8.start = 1'b0;
        if1.start = 1'b0;
        step();
        step();
        chk("post_rst_idle_busy8", if8.busy, 0);
        chk("post_rst_idle_done8", if8.done, 0);

        for (int i = 0; i < 7; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].cout, 0, $sformatf("vec%0d", i));
            step();
        end

        op8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 3, "start_busy");
        for (int i = 0; i < 6; i++) begin
            step();
            chk("start_busy_no_second_done", if8.done, 0);
            chk("start_busy_no_restart", if8.busy, 0);
        end

        if8.a     = 8'h80;
        if8.b     = 8'h80;
        if8.cin   = 1'b0;
        if8.start = 1'b1;
        q8.push_back({1'b1, 8'h00});
        step();
        if8.start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        q8.delete();
        step();
        rst     = 1'b0;
        prev_s8 = 8'h00;
        prev_c8 = 1'b0;
        chk("abort_s", if8.s, 0);
        chk("abort_cout", if8.cout, 0);
        chk("abort_busy", if8.busy, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("abort_no_done", if8.done, 0);
        end
        op8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 0, "post_abort");
        step();

        op8(8'h55, 8'h0A, 1'b0, 8'h5F, 1'b0, 0, "b2b_first");
        op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 0, "b2b_second");
        step();

        for (int i = 0; i < 8; i++) begin
            logic [2:0] bits;
            logic [1:0] exp;
            int         cyc;
            bits      = 3'(i);
            exp       = {1'b0, bits[2]} + {1'b0, bits[1]} + {1'b0, bits[0]};
            if1.a     = bits[2];
            if1.b     = bits[1];
            if1.cin   = bits[0];
            if1.start = 1'b1;
            q1.push_back(exp);
            step();
            if1.start = 1'b0;
            cyc = 1;
            while (!if1.done && cyc < 10) begin
                step();
                cyc++;
            end
            chk($sformatf("w1_latency_%0d", i), cyc, 2);
            step();
        end

        step();
        step();
        chk("w8_scoreboard_drained", q8.size(), 0);
        chk("w1_scoreboard_drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
